booth_div: RTL and testbench

Sequential signed divider, the inverse companion to the combinational Booth multiplier in the arithmetic datapath. It accepts a WIDTH-bit two's-complement dividend and divisor on a start strobe and computes one quotient bit per clock using restoring division on magnitudes. It then returns quotient and remainder with a one-cycle done pulse. It is used where `booth` products must be divided back, and checked as `dividend == quotient*divisor + remainder`.

---
 rtl/booth_div_if.sv | 25 ++
 rtl/booth_div.sv | 114 +++++++++++
 tb/tb_booth_div.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/booth_div_if.sv
// Operand/result bundle for the sequential signed divider.
// start is a one-cycle request honoured only while busy is low; done is a one-cycle pulse from which results are valid.
interface booth_div_if #(
    parameter int WIDTH = 6
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic [1:0]       dbg_state;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, dbg_state
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, dbg_state
    );
endinterface

// File: rtl/booth_div.sv
// Sequential signed divider: restoring division on operand magnitudes, one quotient
// bit per clock, followed by a sign-fixup cycle that registers the results.
module booth_div #(
    parameter int WIDTH = 6
) (
    input logic       clk,
    input logic       rst_n,
    booth_div_if.slave bus
);
    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic             neg_q, neg_r, dvs_zero;
    logic [WIDTH-1:0] dvd_mag, dvs_mag, dvd_raw;
    logic [WIDTH:0]   prem;
    logic             done_q, dbz_q;
    logic [WIDTH-1:0] quo_q, rem_q;

    logic [WIDTH-1:0] dvd_abs, dvs_abs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;

    // |-2^(WIDTH-1)| wraps to 2^(WIDTH-1), which is exact when read as unsigned.
    assign dvd_abs = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    assign dvs_abs = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
    assign shifted = {prem[WIDTH-1:0], dvd_mag[WIDTH-1]};
    assign trial   = {1'b0, shifted} - {2'b00, dvs_mag};

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = CALC;
            CALC:    if (cnt == LAST) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dvs_zero <= 1'b0;
            dvd_mag  <= '0;
            dvs_mag  <= '0;
            dvd_raw  <= '0;
            prem     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            quo_q    <= '0;
            rem_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        neg_q    <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        neg_r    <= bus.dividend[WIDTH-1];
                        dvs_zero <= (bus.divisor == '0);
                        dvd_mag  <= dvd_abs;
                        dvs_mag  <= dvs_abs;
                        dvd_raw  <= bus.dividend;
                        prem     <= '0;
                        cnt      <= '0;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    // The dividend register doubles as the quotient shift register.
                    if (!trial[WIDTH+1]) begin
                        prem    <= trial[WIDTH:0];
                        dvd_mag <= {dvd_mag[WIDTH-2:0], 1'b1};
                    end else begin
                        prem    <= shifted;
                        dvd_mag <= {dvd_mag[WIDTH-2:0], 1'b0};
                    end
                end
                FIX: begin
                    done_q <= 1'b1;
                    dbz_q  <= dvs_zero;
                    if (dvs_zero) begin
                        quo_q <= '1;
                        rem_q <= dvd_raw;
                    end else begin
                        quo_q <= neg_q ? -dvd_mag : dvd_mag;
                        rem_q <= neg_r ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.dbg_state   = state;
endmodule

// File: tb/tb_booth_div.sv
// Directed and exhaustive checks for booth_div at WIDTH=6: latency, signs, divide-by-zero,
// handshake rules and reset behaviour, with results scored from an expected queue.
module tb_booth_div;
    localparam int W  = 6;
    localparam int EW = 2 * W + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    booth_div_if #(.WIDTH(W)) bus_if ();
    booth_div #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus_if));

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_err  = 0;
    int n_done = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every done pops one expected {quotient, remainder, div_by_zero}.
    always @(negedge clk) begin
        if (rst_n && bus_if.done) begin
            n_done++;
            check("busy_with_done", 32'(bus_if.busy), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_e = exp_q.pop_front();
                check("quotient", 32'(bus_if.quotient), 32'(mon_e[EW-1 -: W]));
                check("remainder", 32'(bus_if.remainder), 32'(mon_e[W:1]));
                check("div_by_zero", 32'(bus_if.div_by_zero), 32'(mon_e[0]));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the sampling edge.
    task automatic issue(input int a, input int b, input int q, input int r, input bit dz);
        bus_if.start    = 1'b1;
        bus_if.dividend = W'(a);
        bus_if.divisor  = W'(b);
        exp_q.push_back({W'(q), W'(r), dz});
        @(negedge clk);
        bus_if.start    = 1'b0;
        bus_if.dividend = W'($urandom_range(0, 63));
        bus_if.divisor  = W'($urandom_range(0, 63));
    endtask

    task automatic wait_done(output int cyc, output int bc);
        cyc = 0;
        bc  = 0;
        while (!bus_if.done && cyc < 20) begin
            if (bus_if.busy) bc++;
            @(negedge clk);
            cyc++;
        end
        if (!bus_if.done) begin
            check("timeout", 32'(cyc), 32'(W + 1));
            exp_q.delete();
        end
    endtask

    task automatic check_zeroed(input string tag);
        check({tag, "_busy"}, 32'(bus_if.busy), 32'd0);
        check({tag, "_done"}, 32'(bus_if.done), 32'd0);
        check({tag, "_quotient"}, 32'(bus_if.quotient), 32'd0);
        check({tag, "_remainder"}, 32'(bus_if.remainder), 32'd0);
        check({tag, "_dbz"}, 32'(bus_if.div_by_zero), 32'd0);
        check({tag, "_state"}, 32'(bus_if.dbg_state), 32'd0);
    endtask

    int va[10] = '{ 13, -13,  13, -13, 0, -32, -32,  31, 7, 8};
    int vb[10] = '{  4,   4,  -4,  -4, 5,  -1,   1, -32, 0, 2};
    int vq[10] = '{  3,  -3,  -3,   3, 0, -32, -32,   0, -1, 4};
    int vr[10] = '{  1,  -1,   1,  -1, 0,   0,   0,  31, 7, 0};
    bit vz[10] = '{  0,   0,   0,   0, 0,   0,   0,   0, 1, 0};

    initial begin
        int cyc, bc, d0, q, r;
        bit dz;
        bus_if.start    = 1'b0;
        bus_if.dividend = '0;
        bus_if.divisor  = '0;
        repeat (3) @(negedge clk);
        check_zeroed("reset");
        rst_n = 1'b1;
        @(negedge clk);

        issue(13, 4, 3, 1, 0);
        wait_done(cyc, bc);
        check("latency_13_4", 32'(cyc), 32'(W + 1));
        check("busy_cycles_13_4", 32'(bc), 32'(W + 1));
        @(negedge clk);
        check("done_single_cycle", 32'(bus_if.done), 32'd0);

        for (int i = 0; i < 10; i++) begin
            issue(va[i], vb[i], vq[i], vr[i], vz[i]);
            wait_done(cyc, bc);
            check($sformatf("latency_vec%0d", i), 32'(cyc), 32'(W + 1));
            @(negedge clk);
        end

        // start pulses mid-run must be dropped.
        d0 = n_done;
        issue(-20, 3, -6, -2, 0);
        for (int c = 1; c <= 12; c++) begin
            bus_if.start    = (c == 2 || c == 4);
            bus_if.dividend = W'(1);
            bus_if.divisor  = W'(1);
            @(negedge clk);
        end
        bus_if.start = 1'b0;
        check("ignored_start_dones", 32'(n_done - d0), 32'd1);

        // A request in the done cycle is accepted.
        issue(25, -4, -6, 1, 0);
        wait_done(cyc, bc);
        issue(-9, 2, -4, -1, 0);
        wait_done(cyc, bc);
        check("b2b_latency", 32'(cyc), 32'(W + 1));
        @(negedge clk);

        // Reset pulse on CALC step 3 aborts the run.
        issue(30, 7, 4, 2, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_zeroed("midrun_reset");
        rst_n = 1'b1;
        exp_q.delete();
        d0 = n_done;
        repeat (12) @(negedge clk);
        check("aborted_no_done", 32'(n_done - d0), 32'd0);
        issue(20, 3, 6, 2, 0);
        wait_done(cyc, bc);
        check("after_reset_latency", 32'(cyc), 32'(W + 1));
        @(negedge clk);

        // Reset beats a simultaneous start.
        rst_n           = 1'b0;
        bus_if.start    = 1'b1;
        bus_if.dividend = W'(5);
        bus_if.divisor  = W'(1);
        @(negedge clk);
        bus_if.start = 1'b0;
        rst_n        = 1'b1;
        check("reset_vs_start_busy", 32'(bus_if.busy), 32'd0);
        d0 = n_done;
        repeat (10) @(negedge clk);
        check("reset_vs_start_no_done", 32'(n_done - d0), 32'd0);

        for (int a = -32; a < 32; a++) begin
            for (int b = -32; b < 32; b++) begin
                if (b == 0) begin
                    q  = -1;
                    r  = a;
                    dz = 1'b1;
                end else begin
                    q  = a / b;
                    r  = a % b;
                    dz = 1'b0;
                end
                issue(a, b, q, r, dz);
                wait_done(cyc, bc);
            end
        end

        repeat (2) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
